// File: rtl/tx_byte_scheduler.sv
// tx_byte_scheduler: byte FIFO that releases one queued byte (or IDLE_BYTE) per 16-symbol CRC frame
module tx_byte_scheduler #(
  parameter int DEPTH = 4,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  sign_cnt,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic [4:0]  fill_level,
  output logic [15:0] frames_sent,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0] count;
  logic [3:0] prev_cnt;
  logic boundary, push, pop;
  always_comb begin
    in_ready = count != 5'(DEPTH);
    fill_level = count;
    boundary = prev_cnt == 4'hF && sign_cnt == 4'h0;
    push = in_valid && in_ready;
    pop = boundary && count != 5'd0;
  end
  // Storage needs no reset: count and pointers alone define what is queued.
  always_ff @(posedge sys_clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge sys_clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= 5'd0;
      prev_cnt <= 4'h0;
      data_out <= IDLE_BYTE;
      data_valid <= 1'b0;
      frames_sent <= 16'd0;
      overflow <= 1'b0;
    end else begin
      prev_cnt <= sign_cnt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + 5'(push) - 5'(pop);
      if (boundary) begin
        data_out <= pop ? mem[rd_ptr] : IDLE_BYTE;
        data_valid <= pop;
      end
      if (pop && frames_sent != 16'hFFFF) frames_sent <= frames_sent + 16'd1;
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_tx_byte_scheduler.sv
// tb_tx_byte_scheduler: directed scenarios for the frame-paced byte scheduler
module tb_tx_byte_scheduler;
  logic sys_clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] sign_cnt = 4'h0;
  logic [7:0] data_out;
  logic data_valid;
  logic [4:0] fill_level;
  logic [15:0] frames_sent;
  logic overflow;
  int checks = 0;
  int errors = 0;

  tx_byte_scheduler #(.DEPTH(4), .IDLE_BYTE(8'h00)) dut (
    .sys_clk(sys_clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sign_cnt(sign_cnt), .data_out(data_out),
    .data_valid(data_valid), .fill_level(fill_level), .frames_sent(frames_sent),
    .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  task cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task run_sym(input logic [3:0] s);
    sign_cnt = s;
    cyc();
  endtask

  task frame();
    for (int s = 1; s < 16; s++) run_sym(4'(s));
    run_sym(4'h0);
  endtask

  task push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task apply_reset();
    sign_cnt = 4'h0;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task test_reset();
    #12;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", data_valid); end
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL reset_frames got %0d exp 0", frames_sent); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    reset = 1'b1;
  endtask

  task test_idle();
    for (int f = 0; f < 3; f++) begin
      frame();
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL idle_data f%0d got %h exp 00", f, data_out); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL idle_valid f%0d got %b exp 0", f, data_valid); end
      checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL idle_frames f%0d got %0d exp 0", f, frames_sent); end
    end
  endtask

  task test_single();
    push_byte(8'hBB);
    checks++; if (fill_level !== 5'd1) begin errors++; $display("FAIL single_fill got %0d exp 1", fill_level); end
    for (int s = 1; s < 16; s++) run_sym(4'(s));
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", data_valid); end
    run_sym(4'h0);
    checks++; if (data_out !== 8'hBB) begin errors++; $display("FAIL single_data got %h exp bb", data_out); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", data_valid); end
    checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL single_frames got %0d exp 1", frames_sent); end
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL single_fill0 got %0d exp 0", fill_level); end
    for (int s = 1; s < 16; s++) begin
      run_sym(4'(s));
      checks++; if (data_out !== 8'hBB || data_valid !== 1'b1) begin errors++; $display("FAIL single_hold s%0d got %h/%b exp bb/1", s, data_out, data_valid); end
    end
    run_sym(4'h0);
    checks++; if (data_out !== 8'h00 || data_valid !== 1'b0) begin errors++; $display("FAIL single_idle got %h/%b exp 00/0", data_out, data_valid); end
    checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL single_frames_hold got %0d exp 1", frames_sent); end
  endtask

  task test_full();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) push_byte(exp_b[i]);
    checks++; if (fill_level !== 5'd4) begin errors++; $display("FAIL full_fill got %0d exp 4", fill_level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", in_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_pre got %b exp 0", overflow); end
    push_byte(8'h55);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf got %b exp 1", overflow); end
    checks++; if (fill_level !== 5'd4) begin errors++; $display("FAIL full_refused got %0d exp 4", fill_level); end
    for (int i = 0; i < 4; i++) begin
      frame();
      checks++; if (data_out !== exp_b[i] || data_valid !== 1'b1) begin errors++; $display("FAIL full_order i%0d got %h/%b exp %h/1", i, data_out, data_valid, exp_b[i]); end
      checks++; if (fill_level !== 5'(3 - i)) begin errors++; $display("FAIL full_drain i%0d got %0d exp %0d", i, fill_level, 3 - i); end
      checks++; if (frames_sent !== 16'(2 + i)) begin errors++; $display("FAIL full_frames i%0d got %0d exp %0d", i, frames_sent, 2 + i); end
    end
    frame();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL full_no55 got %b exp 0", data_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_sticky got %b exp 1", overflow); end
  endtask

  task test_full_boundary();
    logic [7:0] exp_b [4];
    exp_b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    apply_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fb_ovf_clear got %b exp 0", overflow); end
    for (int i = 0; i < 4; i++) push_byte(exp_b[i]);
    for (int s = 1; s < 16; s++) run_sym(4'(s));
    in_valid = 1'b1;
    in_data = 8'h66;
    run_sym(4'h0);
    in_valid = 1'b0;
    checks++; if (data_out !== 8'hA0) begin errors++; $display("FAIL fb_data got %h exp a0", data_out); end
    checks++; if (fill_level !== 5'd3) begin errors++; $display("FAIL fb_fill got %0d exp 3", fill_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fb_ovf got %b exp 1", overflow); end
    checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL fb_frames got %0d exp 1", frames_sent); end
    for (int i = 1; i < 4; i++) begin
      frame();
      checks++; if (data_out !== exp_b[i] || data_valid !== 1'b1) begin errors++; $display("FAIL fb_order i%0d got %h/%b exp %h/1", i, data_out, data_valid, exp_b[i]); end
    end
    frame();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL fb_no66 got %h/%b exp 00/0", data_out, data_valid); end
  endtask

  task test_back_to_back();
    push_byte(8'hC1);
    push_byte(8'hC2);
    checks++; if (fill_level !== 5'd2) begin errors++; $display("FAIL b2b_fill got %0d exp 2", fill_level); end
    for (int s = 1; s < 16; s++) run_sym(4'(s));
    in_valid = 1'b1;
    in_data = 8'hC3;
    run_sym(4'h0);
    in_valid = 1'b0;
    checks++; if (data_out !== 8'hC1) begin errors++; $display("FAIL b2b_data got %h exp c1", data_out); end
    checks++; if (fill_level !== 5'd2) begin errors++; $display("FAIL b2b_fill_same got %0d exp 2", fill_level); end
    frame();
    checks++; if (data_out !== 8'hC2 || fill_level !== 5'd1) begin errors++; $display("FAIL b2b_second got %h/%0d exp c2/1", data_out, fill_level); end
    frame();
    checks++; if (data_out !== 8'hC3 || fill_level !== 5'd0) begin errors++; $display("FAIL b2b_third got %h/%0d exp c3/0", data_out, fill_level); end
  endtask

  task test_jump();
    push_byte(8'hF1);
    for (int s = 1; s < 8; s++) run_sym(4'(s));
    run_sym(4'h0);
    checks++; if (data_out !== 8'hC3 || fill_level !== 5'd1) begin errors++; $display("FAIL jump_7to0 got %h/%0d exp c3/1", data_out, fill_level); end
    run_sym(4'hF);
    run_sym(4'h3);
    checks++; if (fill_level !== 5'd1) begin errors++; $display("FAIL jump_15to3 got %0d exp 1", fill_level); end
    run_sym(4'hF);
    run_sym(4'h0);
    checks++; if (data_out !== 8'hF1 || fill_level !== 5'd0) begin errors++; $display("FAIL jump_real got %h/%0d exp f1/0", data_out, fill_level); end
  endtask

  task test_reset_mid();
    apply_reset();
    push_byte(8'hD1);
    push_byte(8'hD2);
    push_byte(8'hD3);
    push_byte(8'hD4);
    frame();
    checks++; if (data_out !== 8'hD1 || fill_level !== 5'd3) begin errors++; $display("FAIL mid_pre got %h/%0d exp d1/3", data_out, fill_level); end
    for (int s = 1; s < 9; s++) run_sym(4'(s));
    #2;
    reset = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data got %h exp 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", data_valid); end
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL mid_fill got %0d exp 0", fill_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", in_ready); end
    checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL mid_frames got %0d exp 0", frames_sent); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b exp 0", overflow); end
    cyc();
    reset = 1'b1;
    sign_cnt = 4'h9;
    push_byte(8'hE1);
    for (int s = 10; s < 16; s++) run_sym(4'(s));
    checks++; if (data_valid !== 1'b0 || fill_level !== 5'd1) begin errors++; $display("FAIL mid_wait got %b/%0d exp 0/1", data_valid, fill_level); end
    run_sym(4'h0);
    checks++; if (data_out !== 8'hE1 || data_valid !== 1'b1) begin errors++; $display("FAIL mid_first got %h/%b exp e1/1", data_out, data_valid); end
    checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL mid_frames_after got %0d exp 1", frames_sent); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_full();
    test_full_boundary();
    test_back_to_back();
    test_jump();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
